// File: rtl/count_checker.sv
`default_nettype none
//==============================================================================
// Module   : count_checker
// Purpose  : Checks framed count sequences (start, step, end) on enabled beats,
//            flagging the first protocol error and counting good frames.
// Revision : 1.0 - initial release
//==============================================================================
module count_checker #(
   parameter int COUNT_WIDTH = 4,
   parameter int COUNT_START = 0,
   parameter int COUNT_END   = 15,
   parameter int COUNT_INCR  = 1,
   parameter int FRAME_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clk_enable,
   input  logic [COUNT_WIDTH-1:0] in_data,
   input  logic                   in_valid,
   input  logic                   in_last,
   input  logic                   clear,
   output logic                   frame_done,
   output logic                   frame_ok,
   output logic                   err,
   output logic [1:0]             err_code,
   output logic [FRAME_WIDTH-1:0] frame_count,
   output logic [COUNT_WIDTH-1:0] last_data
);

   // Truncation to COUNT_WIDTH makes a negative step wrap modulo 2^COUNT_WIDTH.
   localparam logic [COUNT_WIDTH-1:0] c_start = COUNT_WIDTH'(COUNT_START);
   localparam logic [COUNT_WIDTH-1:0] c_end   = COUNT_WIDTH'(COUNT_END);
   localparam logic [COUNT_WIDTH-1:0] c_incr  = COUNT_WIDTH'(COUNT_INCR);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_run   = 2'd1;
   localparam logic [1:0] c_st_error = 2'd2;

   localparam logic [1:0] c_err_none  = 2'd0;
   localparam logic [1:0] c_err_start = 2'd1;
   localparam logic [1:0] c_err_seq   = 2'd2;
   localparam logic [1:0] c_err_last  = 2'd3;

   logic [1:0]             r_state;
   logic [1:0]             w_next_state;
   logic [COUNT_WIDTH-1:0] r_expected;
   logic [COUNT_WIDTH-1:0] w_next_expected;
   logic                   w_beat;
   logic                   w_is_end;
   logic                   w_complete;
   logic                   w_err_entry;
   logic [1:0]             w_err_cause;

   logic                   r_frame_done;
   logic                   r_frame_ok;
   logic                   r_err;
   logic [1:0]             r_err_code;
   logic [FRAME_WIDTH-1:0] r_frame_count;
   logic [COUNT_WIDTH-1:0] r_last_data;

   logic                   w_next_frame_done;
   logic                   w_next_frame_ok;
   logic                   w_next_err;
   logic [1:0]             w_next_err_code;
   logic [FRAME_WIDTH-1:0] w_next_frame_count;
   logic [COUNT_WIDTH-1:0] w_next_last_data;

   assign w_beat   = clk_enable & in_valid;
   assign w_is_end = (in_data == c_end);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= c_st_idle;
         r_expected <= c_start;
      end else begin
         r_state    <= w_next_state;
         r_expected <= w_next_expected;
      end
   end

   always_comb begin
      w_next_state    = r_state;
      w_next_expected = r_expected;
      w_complete      = 1'b0;
      w_err_entry     = 1'b0;
      w_err_cause     = c_err_none;
      if (clear) begin
         w_next_state    = c_st_idle;
         w_next_expected = c_start;
      end else if (w_beat) begin
         case (r_state)
            c_st_idle: begin
               if (in_data != c_start) begin
                  w_next_state = c_st_error;
                  w_err_entry  = 1'b1;
                  w_err_cause  = c_err_start;
               end else if (w_is_end != in_last) begin
                  w_next_state = c_st_error;
                  w_err_entry  = 1'b1;
                  w_err_cause  = c_err_last;
               end else if (w_is_end) begin
                  w_complete = 1'b1;
               end else begin
                  w_next_state    = c_st_run;
                  w_next_expected = c_start + c_incr;
               end
            end
            c_st_run: begin
               if (in_data != r_expected) begin
                  w_next_state = c_st_error;
                  w_err_entry  = 1'b1;
                  w_err_cause  = c_err_seq;
               end else if (w_is_end != in_last) begin
                  w_next_state = c_st_error;
                  w_err_entry  = 1'b1;
                  w_err_cause  = c_err_last;
               end else if (w_is_end) begin
                  w_complete      = 1'b1;
                  w_next_state    = c_st_idle;
                  w_next_expected = c_start;
               end else begin
                  w_next_expected = r_expected + c_incr;
               end
            end
            c_st_error: begin
            end
            default: begin
               w_next_state    = c_st_idle;
               w_next_expected = c_start;
            end
         endcase
      end
   end

   // Error entry happens only from IDLE/RUN, so the first cause is never overwritten.
   always_comb begin
      w_next_frame_done  = w_complete;
      w_next_frame_ok    = r_frame_ok;
      w_next_err         = r_err;
      w_next_err_code    = r_err_code;
      w_next_frame_count = r_frame_count;
      w_next_last_data   = r_last_data;
      if (clear) begin
         w_next_frame_ok    = 1'b0;
         w_next_err         = 1'b0;
         w_next_err_code    = c_err_none;
         w_next_frame_count = '0;
      end else begin
         if (w_beat && (r_state != c_st_error))
            w_next_last_data = in_data;
         if (w_complete) begin
            w_next_frame_ok = 1'b1;
            if (r_frame_count != '1)
               w_next_frame_count = r_frame_count + FRAME_WIDTH'(1);
         end
         if (w_err_entry) begin
            w_next_frame_ok = 1'b0;
            w_next_err      = 1'b1;
            w_next_err_code = w_err_cause;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frame_done  <= 1'b0;
         r_frame_ok    <= 1'b0;
         r_err         <= 1'b0;
         r_err_code    <= c_err_none;
         r_frame_count <= '0;
         r_last_data   <= '0;
      end else begin
         r_frame_done  <= w_next_frame_done;
         r_frame_ok    <= w_next_frame_ok;
         r_err         <= w_next_err;
         r_err_code    <= w_next_err_code;
         r_frame_count <= w_next_frame_count;
         r_last_data   <= w_next_last_data;
      end
   end

   assign frame_done  = r_frame_done;
   assign frame_ok    = r_frame_ok;
   assign err         = r_err;
   assign err_code    = r_err_code;
   assign frame_count = r_frame_count;
   assign last_data   = r_last_data;

endmodule
`default_nettype wire

// File: tb/tb_count_checker.sv
`default_nettype none
//==============================================================================
// Module   : tb_count_checker
// Purpose  : Directed self-checking bench for count_checker (three parameter sets
//            sharing one stimulus bus).
// Revision : 1.0 - initial release
//==============================================================================
module tb_count_checker;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       clk_enable = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_last = 1'b0;
   logic       clear = 1'b0;
   logic [3:0] in_data = 4'd0;

   logic       fd_a, ok_a, err_a, fd_b, ok_b, err_b, fd_c, ok_c, err_c;
   logic [1:0] ec_a, ec_b, ec_c;
   logic [7:0] fc_a, fc_b;
   logic [1:0] fc_c;
   logic [3:0] ld_a, ld_b, ld_c;

   int passed = 0;
   int total  = 0;
   int done_a = 0;
   int done_b = 0;
   int snap   = 0;

   count_checker dut_a (
      .clk(clk), .rst(rst), .clk_enable(clk_enable), .in_data(in_data),
      .in_valid(in_valid), .in_last(in_last), .clear(clear),
      .frame_done(fd_a), .frame_ok(ok_a), .err(err_a), .err_code(ec_a),
      .frame_count(fc_a), .last_data(ld_a)
   );

   count_checker #(.COUNT_START(14), .COUNT_END(1), .COUNT_INCR(-1)) dut_b (
      .clk(clk), .rst(rst), .clk_enable(clk_enable), .in_data(in_data),
      .in_valid(in_valid), .in_last(in_last), .clear(clear),
      .frame_done(fd_b), .frame_ok(ok_b), .err(err_b), .err_code(ec_b),
      .frame_count(fc_b), .last_data(ld_b)
   );

   count_checker #(.COUNT_START(5), .COUNT_END(5), .FRAME_WIDTH(2)) dut_c (
      .clk(clk), .rst(rst), .clk_enable(clk_enable), .in_data(in_data),
      .in_valid(in_valid), .in_last(in_last), .clear(clear),
      .frame_done(fd_c), .frame_ok(ok_c), .err(err_c), .err_code(ec_c),
      .frame_count(fc_c), .last_data(ld_c)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (fd_a) done_a++;
      if (fd_b) done_b++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drive(input logic ce, input logic v, input logic [3:0] d,
                        input logic l, input logic clr);
      @(negedge clk);
      clk_enable = ce; in_valid = v; in_data = d; in_last = l; clear = clr;
      @(posedge clk);
      #1;
      clk_enable = 1'b0; in_valid = 1'b0; in_last = 1'b0; clear = 1'b0;
   endtask

   // Gap cycles carry valid/last without enable; they must be ignored.
   task automatic beat(input logic [3:0] d, input logic l, input int gap);
      repeat (gap) drive(1'b0, 1'b1, 4'd9, 1'b1, 1'b0);
      drive(1'b1, 1'b1, d, l, 1'b0);
   endtask

   task automatic up_frame(input int gap);
      for (int v = 0; v < 16; v++) beat(4'(v), (v == 15), gap);
   endtask

   task automatic do_clear();
      drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
   endtask

   initial begin
      #1 rst = 1'b1;
      #2;
      chk("rst_frame_done", 32'(fd_a), 32'd0);
      chk("rst_frame_ok",   32'(ok_a), 32'd0);
      chk("rst_err",        32'(err_a), 32'd0);
      chk("rst_err_code",   32'(ec_a), 32'd0);
      chk("rst_frame_cnt",  32'(fc_a), 32'd0);
      chk("rst_last_data",  32'(ld_a), 32'd0);
      @(negedge clk) rst = 1'b0;

      // Full frame with enable every 4th clk.
      up_frame(3);
      chk("f1_done_pulse", 32'(fd_a), 32'd1);
      drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      chk("f1_done_low",   32'(fd_a), 32'd0);
      chk("f1_done_cnt",   32'(done_a), 32'd1);
      chk("f1_frame_ok",   32'(ok_a), 32'd1);
      chk("f1_frame_cnt",  32'(fc_a), 32'd1);
      chk("f1_last_data",  32'(ld_a), 32'd15);
      chk("f1_err",        32'(err_a), 32'd0);

      // Sequence error 0,1,2,4 then beats ignored.
      beat(4'd0, 1'b0, 0); beat(4'd1, 1'b0, 0); beat(4'd2, 1'b0, 0); beat(4'd4, 1'b0, 0);
      chk("seq_err",       32'(err_a), 32'd1);
      chk("seq_code",      32'(ec_a), 32'd2);
      chk("seq_ok",        32'(ok_a), 32'd0);
      chk("seq_last",      32'(ld_a), 32'd4);
      beat(4'd0, 1'b0, 0); beat(4'd1, 1'b0, 0);
      chk("ign_last",      32'(ld_a), 32'd4);
      chk("ign_code",      32'(ec_a), 32'd2);
      chk("ign_cnt",       32'(fc_a), 32'd1);

      // Restart value after a valid gap is still sequence-checked.
      do_clear();
      for (int v = 0; v < 4; v++) beat(4'(v), 1'b0, 0);
      drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      beat(4'd0, 1'b0, 0);
      chk("gap_code",      32'(ec_a), 32'd2);

      // Bad start, then clear with a simultaneous beat.
      do_clear();
      beat(4'd3, 1'b0, 0);
      chk("start_code",    32'(ec_a), 32'd1);
      chk("start_last",    32'(ld_a), 32'd3);
      drive(1'b1, 1'b1, 4'd0, 1'b0, 1'b1);
      chk("clr_err",       32'(err_a), 32'd0);
      chk("clr_code",      32'(ec_a), 32'd0);
      chk("clr_cnt",       32'(fc_a), 32'd0);
      chk("clr_ok",        32'(ok_a), 32'd0);
      chk("clr_last_kept", 32'(ld_a), 32'd3);
      up_frame(0);
      chk("clr_idle_err",  32'(err_a), 32'd0);
      chk("clr_idle_cnt",  32'(fc_a), 32'd1);

      // Last-flag mismatches.
      do_clear();
      for (int v = 0; v < 7; v++) beat(4'(v), 1'b0, 0);
      beat(4'd7, 1'b1, 0);
      chk("early_last",    32'(ec_a), 32'd3);
      do_clear();
      for (int v = 0; v < 15; v++) beat(4'(v), 1'b0, 0);
      beat(4'd15, 1'b0, 0);
      chk("missing_last",  32'(ec_a), 32'd3);
      chk("missing_ok",    32'(ok_a), 32'd0);

      // Reset mid-frame discards the frame.
      do_clear();
      for (int v = 0; v < 6; v++) beat(4'(v), 1'b0, 0);
      #2 rst = 1'b1;
      #1;
      chk("arst_last",     32'(ld_a), 32'd0);
      chk("arst_cnt",      32'(fc_a), 32'd0);
      @(negedge clk) rst = 1'b0;
      snap = done_a;
      up_frame(0);
      drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      chk("arst_done_once", 32'(done_a - snap), 32'd1);
      chk("arst_frame_cnt", 32'(fc_a), 32'd1);

      // Descending frames 14..1 on the second instance.
      do_clear();
      snap = done_b;
      for (int f = 0; f < 2; f++)
         for (int v = 14; v >= 1; v--) beat(4'(v), (v == 1), 1);
      drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      chk("down_cnt",      32'(fc_b), 32'd2);
      chk("down_err",      32'(err_b), 32'd0);
      chk("down_done",     32'(done_b - snap), 32'd2);

      // Single-beat frames and saturation on the third instance.
      do_clear();
      for (int k = 1; k <= 4; k++) begin
         beat(4'd5, 1'b1, 0);
         chk("one_beat_done", 32'(fd_c), 32'd1);
         chk("sat_cnt",       32'(fc_c), (k < 3) ? 32'(k) : 32'd3);
      end
      chk("one_beat_err",  32'(err_c), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
